axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave_pkg.sv | 30 +++
 rtl/axi_lfsr8.sv | 23 ++
 rtl/axi_sram_slave.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI definitions for the SRAM slave: channel FSM encodings, response codes
// and the address-decode helper.
package axi_sram_slave_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // True when addr falls inside [base, base + 4*words).
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [31:0] offset_words;
    offset_words = (addr - base) >> 2;
    return (addr >= base) && (offset_words < words);
  endfunction

endpackage

// File: rtl/axi_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4); maximal length, so a nonzero seed never reaches zero.
module axi_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] state
);

  logic feedback;

  assign feedback = state[7] ^ state[5] ^ state[4] ^ state[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (enable) begin
      state <= {state[6:0], feedback};
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst SRAM slave: independent read and write FSMs over one word array,
// with an optional LFSR-driven response delay.
//
// state  | meaning
// R_IDLE | accepting a read address
// R_WAIT | counting down response delay, then fetching the current beat
// R_DATA | beat presented, waiting for rready
// W_IDLE | accepting a write address (and optionally its first data beat)
// W_DATA | accepting write beats until wlast
// W_WAIT | counting down response delay
// W_RESP | bvalid presented, waiting for bready
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter bit          RAND_DELAY = 1'b1,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        wlast,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  rd_state_t   r_state;
  wr_state_t   w_state;
  logic [31:0] mem [MEM_WORDS];
  logic [7:0]  lfsr_state;
  logic [2:0]  delay_seed;
  logic [31:0] raddr;
  logic [7:0]  rlen;
  logic [7:0]  rbeat;
  logic [2:0]  rdelay;
  logic [31:0] waddr;
  logic        werr;
  logic [2:0]  wdelay;
  logic        w_beat;
  logic        w_beat_ok;
  logic [31:0] w_beat_addr;
  logic        unused_ok;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - MEM_BASE) >> 2);
  endfunction

  axi_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .state  (lfsr_state)
  );

  assign delay_seed = RAND_DELAY ? lfsr_state[2:0] : 3'd0;
  assign unused_ok  = ^{arsize, awsize, awlen, lfsr_state[7:3]};

  // A beat in W_IDLE targets awaddr directly since waddr is not yet loaded.
  always_comb begin
    w_beat      = 1'b0;
    w_beat_addr = waddr;
    if (w_state == W_IDLE && awvalid && wvalid) begin
      w_beat      = 1'b1;
      w_beat_addr = awaddr;
    end else if (w_state == W_DATA && wvalid) begin
      w_beat = 1'b1;
    end
  end

  assign w_beat_ok = addr_in_range(w_beat_addr, MEM_BASE, MEM_WORDS);
  assign wready    = (w_state == W_IDLE) ? awvalid : (w_state == W_DATA);

  // Reset gating keeps an abandoned burst from committing on the reset edge.
  always_ff @(posedge clk) begin
    if (!reset && w_beat && w_beat_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx(w_beat_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rbeat   <= '0;
      rdelay  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            raddr   <= araddr;
            rlen    <= arlen;
            rbeat   <= '0;
            rdelay  <= delay_seed;
            arready <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rdelay == 3'd0) begin
            rvalid <= 1'b1;
            rlast  <= (rbeat == rlen);
            if (addr_in_range(raddr, MEM_BASE, MEM_WORDS)) begin
              rdata <= mem[word_idx(raddr)];
              rresp <= RESP_OKAY;
            end else begin
              rdata <= '0;
              rresp <= RESP_DECERR;
            end
            r_state <= R_DATA;
          end else begin
            rdelay <= rdelay - 3'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              // rdelay is already zero, so R_WAIT fetches the next beat immediately.
              rbeat   <= rbeat + 8'd1;
              raddr   <= raddr + 32'd4;
              r_state <= R_WAIT;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      waddr   <= '0;
      werr    <= 1'b0;
      wdelay  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            awready <= 1'b0;
            wdelay  <= delay_seed;
            if (wvalid) begin
              waddr   <= awaddr + 32'd4;
              werr    <= !w_beat_ok;
              w_state <= wlast ? W_WAIT : W_DATA;
            end else begin
              waddr   <= awaddr;
              werr    <= 1'b0;
              w_state <= W_DATA;
            end
          end
        end
        W_DATA: begin
          if (wvalid) begin
            waddr <= waddr + 32'd4;
            werr  <= werr | !w_beat_ok;
            if (wlast) begin
              wdelay  <= delay_seed;
              w_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (wdelay == 3'd0) begin
            bvalid  <= 1'b1;
            bresp   <= werr ? RESP_DECERR : RESP_OKAY;
            w_state <= W_RESP;
          end else begin
            wdelay <= wdelay - 3'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
